// File: rtl/mem_pkg.sv
// Shared types and default geometry for the memory-stage responder and its data array.
package mem_pkg;

  localparam int DEF_MEMO_LINES = 64;
  localparam int DEF_VECT_SIZE  = 8;
  localparam int DEF_ELEM_SIZE  = 8;
  localparam int ADDR_W         = $clog2(DEF_MEMO_LINES);

  typedef logic [DEF_ELEM_SIZE-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    RD_LAST = 2'd2,
    WR      = 2'd3
  } state_t;

endpackage

// File: rtl/mem_stage_unit_data_mem_sp.sv
// Single-port element memory: synchronous write, synchronous read returning pre-write data.
module data_mem_sp #(
  parameter int LINES = 64,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [LINES];

  // NOTE: the array has no reset branch on purpose; clearing it would turn RAM into flops.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage_unit.sv
// Memory-stage responder: scalar/vector load and store, one element per cycle, with pipeline stall.
module mem_stage_unit
  import mem_pkg::*;
#(
  parameter int MEMO_LINES = DEF_MEMO_LINES,
  parameter int VECT_SIZE  = DEF_VECT_SIZE,
  parameter int ELEM_SIZE  = DEF_ELEM_SIZE
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            enableMem_i,
  input  logic                            flagMemRead_i,
  input  logic                            flagMemWrite_i,
  input  logic                            writeResultV_i,
  input  logic [$clog2(MEMO_LINES)-1:0]   addr_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0]  wdata_i,
  output logic [ELEM_SIZE*VECT_SIZE-1:0]  rdata_o,
  output logic                            rdata_valid_o,
  output logic                            wr_done_o,
  output logic                            stall_o,
  output logic                            err_o
);

  localparam int AW = $clog2(MEMO_LINES);
  localparam int CW = $clog2(VECT_SIZE + 1);
  localparam int IW = (VECT_SIZE > 1) ? $clog2(VECT_SIZE) : 1;
  localparam int DW = ELEM_SIZE * VECT_SIZE;

  state_t                state;
  logic [AW-1:0]         addr_q;
  logic [DW-1:0]         wdata_q;
  logic [DW-1:0]         buf_q;
  logic [DW-1:0]         buf_next;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         req_len;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         cap_idx;
  logic                  accept;
  logic                  illegal;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [ELEM_SIZE-1:0]  mem_wdata;
  logic [ELEM_SIZE-1:0]  mem_rdata;

  assign accept  = (state == IDLE) && enableMem_i && (flagMemRead_i ^ flagMemWrite_i);
  assign illegal = (state == IDLE) && enableMem_i && flagMemRead_i && flagMemWrite_i;
  assign req_len = writeResultV_i ? CW'(VECT_SIZE) : CW'(1);

  // cnt is the next element to issue; the element captured in RD is the one issued a cycle earlier.
  assign wr_idx  = IW'(cnt);
  assign cap_idx = IW'(cnt - CW'(1));

  // Completion cycles drop stall so the held request leaves the pipe register with the result.
  assign stall_o = accept || ((state != IDLE) && !rdata_valid_o && !wr_done_o);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q + AW'(cnt);
    mem_wdata = wdata_q[wr_idx*ELEM_SIZE +: ELEM_SIZE];
    case (state)
      IDLE: begin
        mem_addr  = addr_i;
        mem_wdata = wdata_i[ELEM_SIZE-1:0];
        mem_we    = accept && flagMemWrite_i;
      end
      WR:      mem_we = !wr_done_o;
      default: ;
    endcase
  end

  always_comb begin
    buf_next = buf_q;
    buf_next[cap_idx*ELEM_SIZE +: ELEM_SIZE] = mem_rdata;
  end

  data_mem_sp #(
    .LINES (MEMO_LINES),
    .WIDTH (ELEM_SIZE),
    .AW    (AW)
  ) u_data_mem (
    .clk   (clk_i),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // NOTE: all state below updates with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      buf_q         <= '0;
      len_q         <= '0;
      cnt           <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      wr_done_o     <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      wr_done_o     <= 1'b0;
      err_o         <= illegal;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            len_q   <= req_len;
            cnt     <= CW'(1);
            buf_q   <= '0;
            if (flagMemRead_i) begin
              state <= RD;
            end else begin
              state     <= WR;
              wr_done_o <= (req_len == CW'(1));
            end
          end
        end
        RD: begin
          buf_q <= buf_next;
          cnt   <= cnt + CW'(1);
          // rdata_o only changes once the whole access is assembled, so it holds between loads.
          if (cnt == len_q) begin
            rdata_o       <= buf_next;
            rdata_valid_o <= 1'b1;
            state         <= RD_LAST;
          end
        end
        RD_LAST: state <= IDLE;
        WR: begin
          if (wr_done_o) begin
            state <= IDLE;
          end else begin
            cnt       <= cnt + CW'(1);
            wr_done_o <= ((cnt + CW'(1)) == len_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: requests push expected completions, a monitor pops and compares.
module tb_mem_stage_unit;

  localparam int VECT = 8;

  logic        clk_i;
  logic        rst_i;
  logic        enableMem_i;
  logic        flagMemRead_i;
  logic        flagMemWrite_i;
  logic        writeResultV_i;
  logic [5:0]  addr_i;
  logic [63:0] wdata_i;
  logic [63:0] rdata_o;
  logic        rdata_valid_o;
  logic        wr_done_o;
  logic        stall_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  localparam logic [2:0] K_NONE  = 3'b000;
  localparam logic [2:0] K_LOAD  = 3'b001;
  localparam logic [2:0] K_STORE = 3'b010;
  localparam logic [2:0] K_ERR   = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    int          cyc;
    logic [63:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];

  mem_stage_unit dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enableMem_i    (enableMem_i),
    .flagMemRead_i  (flagMemRead_i),
    .flagMemWrite_i (flagMemWrite_i),
    .writeResultV_i (writeResultV_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .rdata_o        (rdata_o),
    .rdata_valid_o  (rdata_valid_o),
    .wr_done_o      (wr_done_o),
    .stall_o        (stall_o),
    .err_o          (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: any completion pulse must match the oldest expectation in kind, cycle and data.
  always @(negedge clk_i) begin : monitor
    logic [2:0] k;
    exp_t e;
    k = {err_o, wr_done_o, rdata_valid_o};
    if (!rst_i && k != K_NONE) begin
      if (sb.size() == 0) begin
        check("unexpected completion pulse", 64'(k), 64'(K_NONE));
      end else begin
        e = sb.pop_front();
        check({e.name, " kind"}, 64'(k), 64'(e.kind));
        check({e.name, " cycle"}, 64'(cyc), 64'(e.cyc));
        if (e.kind == K_LOAD) check({e.name, " rdata"}, rdata_o, e.data);
      end
    end
  end

  task automatic clear_req();
    enableMem_i    = 1'b0;
    flagMemRead_i  = 1'b0;
    flagMemWrite_i = 1'b0;
    writeResultV_i = 1'b0;
    addr_i         = '0;
    wdata_i        = '0;
  endtask

  // Drive one request (called 1 time unit after a rising edge) and hold it while stall_o is high.
  task automatic do_req(input string name, input logic en, input logic rd, input logic wr,
                        input logic vec, input logic [5:0] a, input logic [63:0] wd,
                        input logic [63:0] exp_data);
    int   t;
    int   n;
    int   n_stall;
    int   exp_stall;
    logic s;
    exp_t e;
    t = cyc;
    n = vec ? VECT : 1;
    e.name = name;
    e.data = exp_data;
    exp_stall = 0;
    if (en && rd && !wr) begin
      e.kind = K_LOAD;  e.cyc = t + n + 1; exp_stall = n + 1; sb.push_back(e);
    end else if (en && wr && !rd) begin
      e.kind = K_STORE; e.cyc = t + n;     exp_stall = n;     sb.push_back(e);
    end else if (en && rd && wr) begin
      e.kind = K_ERR;   e.cyc = t + 1;                        sb.push_back(e);
    end
    enableMem_i    = en;
    flagMemRead_i  = rd;
    flagMemWrite_i = wr;
    writeResultV_i = vec;
    addr_i         = a;
    wdata_i        = wd;
    n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      s = stall_o;
      if (s) n_stall++;
      @(posedge clk_i);
      #1;
      if (!s) break;
    end
    clear_req();
    check({name, " stall cycles"}, 64'(n_stall), 64'(exp_stall));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    clear_req();
    repeat (3) @(posedge clk_i);
    #1;
    check("reset rdata_o", rdata_o, 64'h0);
    check("reset rdata_valid_o", 64'(rdata_valid_o), 64'h0);
    check("reset wr_done_o", 64'(wr_done_o), 64'h0);
    check("reset err_o", 64'(err_o), 64'h0);
    check("reset stall_o", 64'(stall_o), 64'h0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Scalar store / load round trip; upper store bytes must not leak into neighbours.
    do_req("scalar store a5", 1, 0, 1, 0, 6'd5, 64'hDEAD_BEEF_CAFE_00A5, 64'h0);
    do_req("scalar load a5",  1, 1, 0, 0, 6'd5, 64'h0, 64'h0000_0000_0000_00A5);

    // Vector store / load round trip, then overwrite one element with a scalar store.
    do_req("vector store a8", 1, 0, 1, 1, 6'd8, 64'h0807_0605_0403_0201, 64'h0);
    do_req("vector load a8",  1, 1, 0, 1, 6'd8, 64'h0, 64'h0807_0605_0403_0201);
    do_req("scalar store a9", 1, 0, 1, 0, 6'd9, 64'hFFFF_FFFF_FFFF_FFC3, 64'h0);
    do_req("vector load a8 patched", 1, 1, 0, 1, 6'd8, 64'h0, 64'h0807_0605_0403_C301);

    // Wrap-around: 60..63 get 88,77,66,55 and 0..3 get 44,33,22,11.
    do_req("wrap store a60", 1, 0, 1, 1, 6'd60, 64'h1122_3344_5566_7788, 64'h0);
    do_req("scalar load a1",  1, 1, 0, 0, 6'd1,  64'h0, 64'h0000_0000_0000_0033);
    do_req("scalar load a62", 1, 1, 0, 0, 6'd62, 64'h0, 64'h0000_0000_0000_0066);
    do_req("wrap load a60",   1, 1, 0, 1, 6'd60, 64'h0, 64'h1122_3344_5566_7788);

    // Illegal request: error pulse, no stall, memory untouched.
    do_req("illegal a5", 1, 1, 1, 0, 6'd5, 64'h0000_0000_0000_00FF, 64'h0);
    do_req("load a5 after illegal", 1, 1, 0, 0, 6'd5, 64'h0, 64'h0000_0000_0000_00A5);

    // Disabled request: flags ignored.
    do_req("disabled read", 0, 1, 0, 1, 6'd8, 64'h0, 64'h0);
    repeat (4) @(posedge clk_i);
    #1;
    check("disabled read stall_o", 64'(stall_o), 64'h0);

    // Reset during a vector load, asserted in cycle T+3.
    enableMem_i    = 1'b1;
    flagMemRead_i  = 1'b1;
    writeResultV_i = 1'b1;
    addr_i         = 6'd8;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    clear_req();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("abort stall_o", 64'(stall_o), 64'h0);
    check("abort rdata_o", rdata_o, 64'h0);
    check("abort rdata_valid_o", 64'(rdata_valid_o), 64'h0);
    repeat (12) @(posedge clk_i);
    #1;

    // Memory contents survive reset.
    do_req("load a5 after reset", 1, 1, 0, 0, 6'd5, 64'h0, 64'h0000_0000_0000_00A5);

    repeat (5) @(posedge clk_i);
    #1;
    check("outstanding expectations", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
